ad_recover: RTL

- Receive-side counterpart of the ADC sample expander. Accepts a decrypted 128-bit block in which each 16-bit lane carries one replicated sample bit.
- Majority-decodes the 8 lanes back to an 8-bit light-sensor sample. Flags corrupted lanes.
- Presents the sample on a DAC/display bus with a one-cycle active-low write strobe, aligned to the 8-cycle sample slot. Drives the light threshold LED.
- Sits between the AES decrypt core output and the sample sink.

---
 rtl/ad_recover.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ad_recover.sv
// ad_recover: majority-decodes a 128-bit block of 8 replicated
// 16-bit lanes back to one 8-bit sample and writes it to the DAC.
// Ports: ADC_CLK_90/rst_n/locked clock, reset and PLL qualifier;
//   data128_in/data128_valid decrypted block and its one-cycle pulse;
//   dac_data/dac_wr_n sample bus and active-low strobe;
//   led_open threshold LED; lane_bad per-lane corruption flags;
//   err_cnt saturating count of corrupt blocks; ovf sticky drop flag.
module ad_recover #(
    parameter int          DIV    = 8,
    parameter logic [7:0]  THRESH = 8'h0F
) (
    input  logic         ADC_CLK_90,
    input  logic         rst_n,
    input  logic         locked,
    input  logic [127:0] data128_in,
    input  logic         data128_valid,
    output logic [7:0]   dac_data,
    output logic         dac_wr_n,
    output logic         led_open,
    output logic [7:0]   lane_bad,
    output logic [15:0]  err_cnt,
    output logic         ovf
);

    localparam int             CW        = $clog2(DIV);
    localparam logic [CW-1:0]  SLOT_LAST = CW'(DIV - 1);

    if (DIV < 4 || (DIV & (DIV - 1)) != 0) begin : g_bad_div
        $error("ad_recover: DIV must be a power of 2, at least 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT_SLOT,
        WRITE
    } state_t;

    state_t         state;
    logic [CW-1:0]  slot;
    logic [127:0]   blk;
    logic [7:0]     dec_q;
    logic [7:0]     bad_q;
    logic [7:0]     dec_c;
    logic [7:0]     bad_c;
    logic [4:0]     pop;
    logic           wr_q;

    // Lane majority vote: 8 of 16 is a tie and resolves to 0.
    always_comb begin
        dec_c = '0;
        bad_c = '0;
        pop   = '0;
        for (int k = 0; k < 8; k++) begin
            pop = '0;
            for (int b = 0; b < 16; b++) begin
                pop = pop + 5'(blk[16*k+b]);
            end
            dec_c[k] = (pop >= 5'd9);
            bad_c[k] = (pop != 5'd0) && (pop != 5'd16);
        end
    end

    // The strobe register holds while unlocked, so gate it here to
    // keep the bus quiet; a held WRITE strobes once relock returns.
    assign dac_wr_n = wr_q | ~locked;

    always_ff @(posedge ADC_CLK_90 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot     <= '0;
            blk      <= '0;
            dec_q    <= '0;
            bad_q    <= '0;
            wr_q     <= 1'b1;
            dac_data <= '0;
            led_open <= 1'b0;
            lane_bad <= '0;
            err_cnt  <= '0;
            ovf      <= 1'b0;
        end else if (locked) begin
            slot <= slot + 1'b1;
            wr_q <= 1'b1;
            if (data128_valid && state != IDLE) begin
                ovf <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (data128_valid) begin
                        blk   <= data128_in;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    dec_q <= dec_c;
                    bad_q <= bad_c;
                    state <= WAIT_SLOT;
                end
                WAIT_SLOT: begin
                    // Outputs load on the edge into WRITE so the
                    // strobe sits in the WRITE cycle itself.
                    if (slot == SLOT_LAST) begin
                        state    <= WRITE;
                        wr_q     <= 1'b0;
                        dac_data <= dec_q;
                        lane_bad <= bad_q;
                        led_open <= (dec_q > THRESH);
                        if (bad_q != 8'd0 && err_cnt != 16'hFFFF) begin
                            err_cnt <= err_cnt + 16'd1;
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
